// File: rtl/par2ser_tx_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
// State encoding matches the frame phases: idle, start bit, data bits, stop bit.
package par2ser_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/par2ser_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each period.
// clr restarts the period so the first bit after acceptance is full length.
module par2ser_tx_bit_timer
    import par2ser_tx_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = clog2_min1(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntMax);
        cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-in, serial-out transmitter: start bit, LSB-first data, stop bit,
// each bit held DIV cycles. All outputs come straight from flops.
module par2ser_tx
    import par2ser_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ena_i,
    output logic             ready_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned IdxW = clog2_min1(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             sout_q, sout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tick;

    assign accept = (state_q == StIdle) && ena_i;

    par2ser_tx_bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (accept),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (ena_i) begin
                    state_d = StStart;
                    shift_d = data_i;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops.
    always_comb begin
        sout_d  = 1'b1;
        if (state_d == StStart) begin
            sout_d = 1'b0;
        end else if (state_d == StData) begin
            sout_d = shift_d[0];
        end
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        done_d  = (state_q == StStop) && tick;
    end

    assign sout_o  = sout_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
